// File: rtl/hdmi_cfg_sequencer.sv
// Walks a register table after power-up or a hot-plug event and issues one I2C byte
// write per entry through an external byte-write master, retrying NACKed writes.
module hdmi_cfg_sequencer #(
  parameter int         POWERUP_CYC = 10000000,
  parameter int         NUM_REGS    = 31,
  parameter int         RETRY_MAX   = 3,
  parameter logic [7:0] DEV_ADDR    = 8'h72
) (
  input  logic        clk50,
  input  logic        rst,
  input  logic        hdmi_txint,
  output logic [5:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        wr_req,
  output logic [7:0]  wr_dev,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  input  logic        wr_done,
  input  logic        wr_nack,
  output logic        ready,
  output logic        cfg_err,
  output logic        busy
);
  localparam int CNT_W = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;
  localparam int RTY_W = $clog2(RETRY_MAX + 1);
  localparam logic [CNT_W-1:0] PU_LAST  = CNT_W'((POWERUP_CYC > 0) ? POWERUP_CYC - 1 : 0);
  localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(RETRY_MAX);
  localparam logic [5:0]       IDX_LAST = 6'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    WAIT_PU, FETCH, LATCH, REQ, WAIT_DONE, NEXT, DONE, ERROR
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       idx_q;
  logic [RTY_W-1:0] retry_q;
  logic [RTY_W-1:0] retry_d;
  logic             pend_q;
  logic [2:0]       sync_q;
  logic             wr_req_q;
  logic [7:0]       wr_reg_q;
  logic [7:0]       wr_data_q;
  logic             ready_q;
  logic             cfg_err_q;
  logic             busy_q;
  logic             evt;
  logic             pend_now;
  logic             restart;

  // sync_q[1:0] is the two-flop synchronizer; sync_q[2] holds the previous synced value
  assign evt      = sync_q[1] & ~sync_q[2];
  assign pend_now = pend_q | evt;
  assign retry_d  = retry_q + RTY_W'(1);

  // A restart never cuts a write short: it happens only from idle states, at NEXT,
  // or where retries run out with a hot-plug still pending.
  always_comb begin
    restart = 1'b0;
    case (state_q)
      DONE, ERROR: restart = evt;
      NEXT:        restart = pend_now;
      WAIT_DONE:   restart = wr_done && wr_nack && (retry_d >= RTY_LIM) && pend_now;
      default:     restart = 1'b0;
    endcase
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_PU;
      cnt_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      pend_q    <= 1'b0;
      sync_q    <= '0;
      wr_req_q  <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      sync_q <= {sync_q[1:0], hdmi_txint};
      if (evt && busy_q && state_q != WAIT_PU)
        pend_q <= 1'b1;

      if (restart) begin
        state_q   <= FETCH;
        idx_q     <= '0;
        retry_q   <= '0;
        pend_q    <= 1'b0;
        ready_q   <= 1'b0;
        cfg_err_q <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          WAIT_PU: begin
            if (cnt_q == PU_LAST) begin
              state_q <= FETCH;
              cnt_q   <= '0;
              idx_q   <= '0;
              retry_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          FETCH: state_q <= LATCH;
          LATCH: begin
            wr_reg_q  <= tbl_data[15:8];
            wr_data_q <= tbl_data[7:0];
            wr_req_q  <= 1'b1;
            state_q   <= REQ;
          end
          REQ: begin
            if (wr_ack) begin
              wr_req_q <= 1'b0;
              state_q  <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (wr_done) begin
              if (!wr_nack) begin
                state_q <= NEXT;
              end else if (retry_d < RTY_LIM) begin
                retry_q  <= retry_d;
                wr_req_q <= 1'b1;
                state_q  <= REQ;
              end else begin
                state_q   <= ERROR;
                cfg_err_q <= 1'b1;
                busy_q    <= 1'b0;
              end
            end
          end
          NEXT: begin
            if (idx_q == IDX_LAST) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 6'd1;
              retry_q <= '0;
              state_q <= FETCH;
            end
          end
          DONE, ERROR: ;
          default: state_q <= WAIT_PU;
        endcase
      end
    end
  end

  assign tbl_addr = idx_q;
  assign wr_req   = wr_req_q;
  assign wr_dev   = DEV_ADDR;
  assign wr_reg   = wr_reg_q;
  assign wr_data  = wr_data_q;
  assign ready    = ready_q;
  assign cfg_err  = cfg_err_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Scoreboard bench: a table-walk model queues the expected writes and NACK answers,
// an I2C master model serves requests, and a monitor checks each accepted write.
module tb_hdmi_cfg_sequencer;
  localparam int PU = 16;
  localparam int NR = 4;
  localparam int RM = 2;

  logic        clk50 = 1'b0;
  logic        rst = 1'b1;
  logic        hdmi_txint = 1'b0;
  logic [5:0]  tbl_addr;
  logic [15:0] tbl_data = '0;
  logic        wr_req;
  logic [7:0]  wr_dev, wr_reg, wr_data;
  logic        wr_ack, wr_done, wr_nack;
  logic        ready, cfg_err, busy;

  int          n_chk = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          spur_n = 0;
  logic [15:0] exp_q[$];
  bit          nack_q[$];
  logic [15:0] tbl_mem[64];
  int          nk_arr[NR];

  hdmi_cfg_sequencer #(
    .POWERUP_CYC(PU), .NUM_REGS(NR), .RETRY_MAX(RM), .DEV_ADDR(8'h72)
  ) dut (
    .clk50(clk50), .rst(rst), .hdmi_txint(hdmi_txint),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .wr_req(wr_req), .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_done(wr_done), .wr_nack(wr_nack),
    .ready(ready), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk50 = ~clk50;

  // synchronous table: data valid one cycle after the address
  always @(posedge clk50) tbl_data <= tbl_mem[tbl_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Each entry is tried until it is acked or RM attempts have been NACKed.
  function automatic bit plan_entries(input int upto);
    for (int e = 0; e < upto; e++) begin
      int tries;
      tries = (nk_arr[e] >= RM) ? RM : nk_arr[e] + 1;
      for (int a = 0; a < tries; a++) begin
        exp_q.push_back(tbl_mem[e]);
        nack_q.push_back(a < nk_arr[e]);
      end
      if (nk_arr[e] >= RM) return 1'b0;
    end
    return 1'b1;
  endfunction

  // I2C master: ack two cycles after the request, done ten cycles after the ack
  initial begin : master
    int m_st, m_cnt, spur_done;
    m_st = 0; m_cnt = 0; spur_done = 0;
    wr_ack = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
    forever begin
      @(posedge clk50); #1;
      if (rst) begin
        m_st = 0; wr_ack = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
      end else begin
        case (m_st)
          0: begin
            if (wr_req) m_st = 1;
            else if (spur_done != spur_n) begin
              spur_done++;
              wr_ack = 1'b1; wr_done = 1'b1; wr_nack = 1'b1; m_st = 5;
            end
          end
          1: begin wr_ack = 1'b1; m_st = 2; end
          2: begin wr_ack = 1'b0; m_cnt = 0; m_st = 3; end
          3: begin
            m_cnt++;
            if (m_cnt == 9) begin
              wr_done = 1'b1;
              if (nack_q.size() > 0) wr_nack = nack_q.pop_front();
              else wr_nack = 1'b0;
              m_st = 4;
            end
          end
          default: begin wr_ack = 1'b0; wr_done = 1'b0; wr_nack = 1'b0; m_st = 0; end
        endcase
      end
    end
  end

  initial begin : monitor
    logic [15:0] last_w, e;
    bit inflight;
    inflight = 1'b0; last_w = '0;
    forever begin
      @(negedge clk50);
      if (rst) inflight = 1'b0;
      else begin
        if (wr_req && wr_ack) begin
          acc_cnt++;
          $display("[%0t] write dev=%02h reg=%02h data=%02h", $time, wr_dev, wr_reg, wr_data);
          chk("wr_dev", 32'(wr_dev), 32'h72);
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_write: got %04h, required no write", {wr_reg, wr_data});
          end else begin
            e = exp_q.pop_front();
            chk("write_order", 32'({wr_reg, wr_data}), 32'(e));
            last_w = e; inflight = 1'b1;
          end
        end
        if (wr_done && inflight) begin
          chk("hold_until_done", 32'({wr_reg, wr_data}), 32'(last_w));
          inflight = 1'b0;
        end
      end
    end
  end

  task automatic txint_edge();
    @(posedge clk50); #1 hdmi_txint = 1'b0;
    repeat (3) @(posedge clk50);
    #1 hdmi_txint = 1'b1;
  endtask

  task automatic wait_end(input string tag, input bit exp_ok);
    int n;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk50); n++; end
    n = 0;
    while (busy && n < 4000) begin @(negedge clk50); n++; end
    chk({tag, "_finished"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'(exp_ok));
    chk({tag, "_cfg_err"}, 32'(cfg_err), 32'(!exp_ok));
    chk({tag, "_all_writes_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_nk(input int a, input int b, input int c, input int d);
    nk_arr[0] = a; nk_arr[1] = b; nk_arr[2] = c; nk_arr[3] = d;
  endtask

  initial begin : stim
    int n, m, base;
    bit ok;
    tbl_mem[0] = 16'h4110; tbl_mem[1] = 16'h9803;
    tbl_mem[2] = 16'h9AE0; tbl_mem[3] = 16'hD603;
    for (int i = 4; i < 64; i++) tbl_mem[i] = '0;
    repeat (3) @(negedge clk50);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_dev", 32'(wr_dev), 32'h72);

    // clean run after power-up
    set_nk(0, 0, 0, 0);
    ok = plan_entries(NR);
    rst = 1'b0;
    n = 0;
    while (!wr_req && n < 60) begin @(posedge clk50); n++; @(negedge clk50); end
    chk("pu_wait_window", 32'(n >= PU + 1 && n <= PU + 4), 32'd1);
    wait_end("clean", ok);

    // stray ack/done while idle must be ignored
    spur_n++;
    repeat (6) @(negedge clk50);
    n = 0;
    repeat (10) begin @(negedge clk50); if (wr_req) n++; end
    chk("spurious_ready", 32'(ready), 32'd1);
    chk("spurious_no_req", 32'(n), 32'd0);

    // hot-plug in DONE
    ok = plan_entries(NR);
    txint_edge();
    n = 0;
    while (ready && n < 10) begin @(negedge clk50); n++; end
    chk("hotplug_ready_drop_le4", 32'(n <= 4), 32'd1);
    m = 0;
    while (!wr_req && m < 20) begin @(negedge clk50); m++; end
    chk("hotplug_no_pu_wait", 32'(wr_req && (n + m) <= 8), 32'd1);
    wait_end("hotplug_done", ok);

    // single NACK on entry 2
    set_nk(0, 0, 1, 0);
    ok = plan_entries(NR);
    txint_edge();
    wait_end("single_nack", ok);

    // retries exhausted on entry 1, then recovery
    set_nk(0, 9, 0, 0);
    ok = plan_entries(NR);
    txint_edge();
    wait_end("exhaust", ok);
    n = 0;
    repeat (40) begin @(negedge clk50); if (wr_req) n++; end
    chk("exhaust_no_more_req", 32'(n), 32'd0);
    set_nk(0, 0, 0, 0);
    ok = plan_entries(NR);
    txint_edge();
    n = 0;
    while (cfg_err && n < 10) begin @(negedge clk50); n++; end
    chk("exhaust_err_clear_le4", 32'(n <= 4), 32'd1);
    wait_end("exhaust_recover", ok);

    // hot-plug while entry 2 is in flight
    ok = plan_entries(3);
    ok = plan_entries(NR);
    base = acc_cnt;
    txint_edge();
    repeat (5) @(posedge clk50);
    #1 hdmi_txint = 1'b0;
    n = 0;
    while (acc_cnt < base + 3 && n < 500) begin @(negedge clk50); n++; end
    chk("midseq_third_write_seen", 32'(acc_cnt - base), 32'd3);
    #1 hdmi_txint = 1'b1;
    wait_end("midseq", ok);

    // reset while a request is outstanding
    txint_edge();
    n = 0;
    while (!wr_req && n < 40) begin @(negedge clk50); n++; end
    chk("rstreq_saw_req", 32'(wr_req), 32'd1);
    #2 rst = 1'b1; hdmi_txint = 1'b0;
    #1 chk("rstreq_async_drop", 32'(wr_req), 32'd0);
    exp_q.delete(); nack_q.delete();
    repeat (3) @(negedge clk50);
    ok = plan_entries(NR);
    rst = 1'b0;
    n = 0;
    while (!wr_req && n < 60) begin
      @(posedge clk50); n++; @(negedge clk50);
      if (n == 5) hdmi_txint = 1'b1;
    end
    chk("rstreq_pu_wait_window", 32'(n >= PU + 1 && n <= PU + 4), 32'd1);
    wait_end("rstreq", ok);

    // randomized tables and NACK patterns
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < NR; e++) begin
        tbl_mem[e] = 16'($urandom);
        nk_arr[e] = ($urandom_range(0, 7) == 0) ? RM : int'($urandom_range(0, 1));
      end
      ok = plan_entries(NR);
      txint_edge();
      wait_end("random", ok);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
